bombjack_rom_loader: RTL and testbench

Upstream stage of `bombjack_top` that owns the ROM download path. It takes the HPS `ioctl_*` byte stream, filters it to ROM downloads (index 0) and decodes each address into one of four ROM regions. It re-times each accepted byte into a single-cycle `dn_*` write pulse, counts bytes and validates the completed image. It holds the core in reset until a complete, in-range image has been loaded.

---
 rtl/bombjack_rom_loader.sv | 180 ++++++++++++++++++
 tb/tb_bombjack_rom_loader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bombjack_rom_loader.sv
// -----------------------------------------------------------------------------
// bombjack_rom_loader
//
// Upstream stage of bombjack_top that owns the ROM download path. It takes the
// HPS ioctl byte stream and keeps only ROM downloads (index 0). Each accepted
// byte is re-timed into a single-cycle dn_* write, tagged with one of four ROM
// regions. The loader counts bytes and validates the finished image, and holds
// the core in reset until a complete, in-range image has been loaded.
//
// Optional feature macro: ROM_CHECKSUM_EN
//   When defined, an 8-bit running sum is kept and exported on `checksum`. The
//   image must then also sum to 8'h00 (it carries a trailing complement byte).
//
// Ports:
//   clk_sys        48 MHz system clock, rising edge
//   reset          asynchronous, active-high
//   ioctl_download HPS transfer active
//   ioctl_index    transfer index (0 = ROM)
//   ioctl_wr       one-cycle byte strobe
//   ioctl_addr     byte address (25 bits)
//   ioctl_dout     byte data
//   dn_addr        registered write address
//   dn_data        registered write data
//   dn_wr          one-cycle write pulse, one cycle after ioctl_wr
//   dn_region      ROM region of dn_addr, valid with dn_wr
//   core_reset     reset request to bombjack_top (low only when READY)
//   rom_ready      a valid image is loaded
//   rom_error      the last download was invalid
//   byte_count     bytes accepted in the current / last download (saturating)
//   checksum       8-bit sum of accepted bytes (ROM_CHECKSUM_EN only)
// -----------------------------------------------------------------------------
module bombjack_rom_loader #(
   parameter int                ADDR_W      = 17,
   parameter logic [ADDR_W-1:0] TOTAL_BYTES = 17'h1C000,
   parameter logic [ADDR_W-1:0] R1_BASE     = 17'h0A000,
   parameter logic [ADDR_W-1:0] R2_BASE     = 17'h10000,
   parameter logic [ADDR_W-1:0] R3_BASE     = 17'h18000
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic [ADDR_W-1:0] dn_addr,
   output logic [7:0]        dn_data,
   output logic              dn_wr,
   output logic [1:0]        dn_region,
   output logic              core_reset,
   output logic              rom_ready,
   output logic              rom_error,
   output logic [ADDR_W:0]   byte_count
`ifdef ROM_CHECKSUM_EN
  ,output logic [7:0]        checksum
`endif
);

   typedef enum logic [2:0] {IDLE, LOAD, CHECK, READY, FAIL} state_t;

   state_t            state;
   logic              overflow;
   logic              start;
   logic              rom_wr;
   logic              in_range;
   logic              load_entry;
   logic              load_active;
   logic              accept;
   logic              drop;
   logic              sum_ok;
   logic [ADDR_W-1:0] addr_lo;
   logic [1:0]        region;

   // A ROM download is index 0 only; other indices (e.g. hiscore) never touch
   // the loader. The range test uses the full 25-bit address so that high
   // address bits cannot alias back into the image.
   assign start    = ioctl_download & (ioctl_index == 8'd0);
   assign rom_wr   = ioctl_wr & (ioctl_index == 8'd0);
   assign addr_lo  = ioctl_addr[ADDR_W-1:0];
   assign in_range = ioctl_addr < {{(25-ADDR_W){1'b0}}, TOTAL_BYTES};

   // A write arriving in the same cycle as `start` belongs to the new
   // download, so the loader treats the entry cycle as already loading.
   assign load_entry  = start & ((state == IDLE) | (state == READY) | (state == FAIL));
   assign load_active = load_entry | (state == LOAD);
   assign accept      = load_active & rom_wr & in_range;
   assign drop        = load_active & rom_wr & ~in_range;

`ifdef ROM_CHECKSUM_EN
   assign sum_ok = (checksum == 8'h00);
`else
   assign sum_ok = 1'b1;
`endif

   // Region decode, highest base first so each region ends where the next
   // one begins.
   always_comb begin
      region = 2'd0;
      if (addr_lo >= R3_BASE)
         region = 2'd3;
      else if (addr_lo >= R2_BASE)
         region = 2'd2;
      else if (addr_lo >= R1_BASE)
         region = 2'd1;
   end

   // Loader FSM with all outputs registered. Entering LOAD wipes the
   // previous download's count, flags and sum; an accepted byte on the entry
   // cycle therefore starts the count at 1 rather than adding to the old one.
   // core_reset follows the state one cycle late, so it drops one cycle after
   // READY is reached.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         dn_addr    <= '0;
         dn_data    <= 8'h00;
         dn_wr      <= 1'b0;
         dn_region  <= 2'd0;
         core_reset <= 1'b1;
         rom_ready  <= 1'b0;
         rom_error  <= 1'b0;
         byte_count <= '0;
         overflow   <= 1'b0;
`ifdef ROM_CHECKSUM_EN
         checksum   <= 8'h00;
`endif
      end else begin
         dn_wr      <= accept;
         core_reset <= (state != READY);

         if (accept) begin
            dn_addr   <= addr_lo;
            dn_data   <= ioctl_dout;
            dn_region <= region;
         end

         if (load_entry) begin
            byte_count <= accept ? {{ADDR_W{1'b0}}, 1'b1} : '0;
            overflow   <= drop;
            rom_ready  <= 1'b0;
            rom_error  <= 1'b0;
`ifdef ROM_CHECKSUM_EN
            checksum   <= accept ? ioctl_dout : 8'h00;
`endif
         end else begin
            if (accept) begin
               if (byte_count != '1)
                  byte_count <= byte_count + {{ADDR_W{1'b0}}, 1'b1};
`ifdef ROM_CHECKSUM_EN
               checksum <= checksum + ioctl_dout;
`endif
            end
            if (drop)
               overflow <= 1'b1;
         end

         case (state)
            IDLE, READY, FAIL: begin
               if (start)
                  state <= LOAD;
            end
            LOAD: begin
               if (!ioctl_download)
                  state <= CHECK;
            end
            CHECK: begin
               if ((byte_count == {1'b0, TOTAL_BYTES}) && !overflow && sum_ok) begin
                  state     <= READY;
                  rom_ready <= 1'b1;
               end else begin
                  state     <= FAIL;
                  rom_error <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bombjack_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_bombjack_rom_loader
//
// Self-checking bench for bombjack_rom_loader. The loader is built with a
// scaled-down image (TOTAL_BYTES = 0x1C0, region bases 0xA0 / 0x100 / 0x180)
// so that several full downloads fit in a short run; the region map keeps the
// same proportions as the real ROM. Every byte expected on dn_* is pushed to a
// scoreboard queue when driven and popped when dn_wr appears.
// Macro ROM_CHECKSUM_EN, when defined, also exercises the checksum port.
// -----------------------------------------------------------------------------
module tb_bombjack_rom_loader;

   localparam int              ADDR_W = 17;
   localparam logic [16:0]     TOTAL  = 17'h001C0;
   localparam logic [16:0]     R1     = 17'h000A0;
   localparam logic [16:0]     R2     = 17'h00100;
   localparam logic [16:0]     R3     = 17'h00180;

   typedef struct {
      logic [16:0] addr;
      logic [7:0]  data;
      logic [1:0]  region;
   } sb_entry_t;

   logic              clk_sys;
   logic              reset;
   logic              ioctl_download;
   logic [7:0]        ioctl_index;
   logic              ioctl_wr;
   logic [24:0]       ioctl_addr;
   logic [7:0]        ioctl_dout;
   logic [ADDR_W-1:0] dn_addr;
   logic [7:0]        dn_data;
   logic              dn_wr;
   logic [1:0]        dn_region;
   logic              core_reset;
   logic              rom_ready;
   logic              rom_error;
   logic [ADDR_W:0]   byte_count;
`ifdef ROM_CHECKSUM_EN
   logic [7:0]        checksum;
`endif

   sb_entry_t sb[$];
   int        checks_total  = 0;
   int        checks_passed = 0;
   int        dn_wr_seen    = 0;
   int        pushes        = 0;

   bombjack_rom_loader #(
      .ADDR_W      (ADDR_W),
      .TOTAL_BYTES (TOTAL),
      .R1_BASE     (R1),
      .R2_BASE     (R2),
      .R3_BASE     (R3)
   ) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .dn_addr        (dn_addr),
      .dn_data        (dn_data),
      .dn_wr          (dn_wr),
      .dn_region      (dn_region),
      .core_reset     (core_reset),
      .rom_ready      (rom_ready),
      .rom_error      (rom_error),
      .byte_count     (byte_count)
`ifdef ROM_CHECKSUM_EN
     ,.checksum       (checksum)
`endif
   );

   // 100 MHz-ish bench clock; the period itself is irrelevant to the design.
   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   // Every comparison in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks_total++;
      if (observed === expected)
         checks_passed++;
      else
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
   endtask

   // Reference region map, written from the base addresses independently of
   // the design.
   function automatic logic [1:0] regionOf(input logic [16:0] a);
      if (a < R1)      return 2'd0;
      else if (a < R2) return 2'd1;
      else if (a < R3) return 2'd2;
      else             return 2'd3;
   endfunction

   // Drives one ioctl_wr strobe. When `begin_dl` is set the download starts
   // in that same cycle. A scoreboard entry is pushed only for bytes the
   // loader should forward: index 0 and address inside the image.
   task automatic applyStimulus(input logic [24:0] addr, input logic [7:0] data,
                                input logic begin_dl);
      sb_entry_t e;
      @(posedge clk_sys);
      #1;
      if (begin_dl) begin
         ioctl_download = 1'b1;
         ioctl_index    = 8'd0;
      end
      ioctl_wr   = 1'b1;
      ioctl_addr = addr;
      ioctl_dout = data;
      if (ioctl_index == 8'd0 && addr < {8'd0, TOTAL}) begin
         e.addr   = addr[16:0];
         e.data   = data;
         e.region = regionOf(addr[16:0]);
         sb.push_back(e);
         pushes++;
      end
      @(posedge clk_sys);
      #1;
      ioctl_wr = 1'b0;
   endtask

   task automatic startDownload(input logic [7:0] idx);
      @(posedge clk_sys);
      #1;
      ioctl_download = 1'b1;
      ioctl_index    = idx;
   endtask

   // Writes addresses 0..n-1. The byte at TOTAL-1 is the complement of the
   // running sum plus `bias`, so a full image sums to `bias`.
   task automatic writeImage(input int n, input logic [7:0] bias);
      logic [7:0] sum;
      logic [7:0] d;
      sum = 8'h00;
      for (int i = 0; i < n; i++) begin
         if (i == int'(TOTAL) - 1)
            d = bias - sum;
         else
            d = 8'((i * 13 + 5) ^ (i >> 8));
         sum = sum + d;
         applyStimulus(25'(i), d, 1'b0);
      end
   endtask

   // Drops ioctl_download and checks the completion timing: no flag after
   // one edge, flag after two, core_reset released after three (good image).
   task automatic endDownload(input logic expect_ok, input string tag);
      @(posedge clk_sys);
      #1;
      ioctl_download = 1'b0;
      @(posedge clk_sys);
      #1;
      checkOutput({tag, "_flag_early"}, {31'd0, rom_ready | rom_error}, 32'd0);
      @(posedge clk_sys);
      #1;
      checkOutput({tag, "_rom_ready"}, {31'd0, rom_ready}, {31'd0, expect_ok});
      checkOutput({tag, "_rom_error"}, {31'd0, rom_error}, {31'd0, ~expect_ok});
      checkOutput({tag, "_core_reset_hold"}, {31'd0, core_reset}, 32'd1);
      @(posedge clk_sys);
      #1;
      checkOutput({tag, "_core_reset"}, {31'd0, core_reset}, {31'd0, ~expect_ok});
   endtask

   // Scoreboard monitor: every dn_wr pulse must match the oldest pending byte.
   always @(negedge clk_sys) begin
      sb_entry_t e;
      if (dn_wr) begin
         dn_wr_seen++;
         if (sb.size() == 0) begin
            checkOutput("dn_wr_unexpected", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            checkOutput("dn_addr", {15'd0, dn_addr}, {15'd0, e.addr});
            checkOutput("dn_data", {24'd0, dn_data}, {24'd0, e.data});
            checkOutput("dn_region", {30'd0, dn_region}, {30'd0, e.region});
         end
      end
   end

   // Test sequence.
   initial begin
      int base;
      reset          = 1'b1;
      ioctl_download = 1'b0;
      ioctl_index    = 8'd0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = 8'h00;

      repeat (3) @(posedge clk_sys);
      #1;
      checkOutput("rst_core_reset", {31'd0, core_reset}, 32'd1);
      checkOutput("rst_rom_ready", {31'd0, rom_ready}, 32'd0);
      checkOutput("rst_rom_error", {31'd0, rom_error}, 32'd0);
      checkOutput("rst_dn_wr", {31'd0, dn_wr}, 32'd0);
      checkOutput("rst_byte_count", {14'd0, byte_count}, 32'd0);
      reset = 1'b0;
      repeat (2) @(posedge clk_sys);
      #1;
      checkOutput("idle_core_reset", {31'd0, core_reset}, 32'd1);

      $display("[TB] full image load");
      base = dn_wr_seen;
      startDownload(8'd0);
      writeImage(int'(TOTAL), 8'h00);
      endDownload(1'b1, "full");
      checkOutput("full_dn_wr_count", 32'(dn_wr_seen - base), {15'd0, TOTAL});
      checkOutput("full_byte_count", {14'd0, byte_count}, {15'd0, TOTAL});
`ifdef ROM_CHECKSUM_EN
      checkOutput("full_checksum", {24'd0, checksum}, 32'd0);
`endif

      $display("[TB] index 3 download while ready");
      base = dn_wr_seen;
      startDownload(8'd3);
      for (int i = 0; i < 4; i++)
         applyStimulus(25'(i), 8'hA5, 1'b0);
      @(posedge clk_sys);
      #1;
      ioctl_download = 1'b0;
      ioctl_index    = 8'd0;
      repeat (4) @(posedge clk_sys);
      #1;
      checkOutput("idx3_dn_wr_count", 32'(dn_wr_seen - base), 32'd0);
      checkOutput("idx3_rom_ready", {31'd0, rom_ready}, 32'd1);
      checkOutput("idx3_core_reset", {31'd0, core_reset}, 32'd0);
      checkOutput("idx3_byte_count", {14'd0, byte_count}, {15'd0, TOTAL});

      $display("[TB] region boundaries, start with write");
      applyStimulus(25'h0009F, 8'h11, 1'b1);
      #1;
      checkOutput("start_wr_count", {14'd0, byte_count}, 32'd1);
      applyStimulus(25'h000A0, 8'h22, 1'b0);
      applyStimulus(25'h000FF, 8'h33, 1'b0);
      applyStimulus(25'h00100, 8'h44, 1'b0);
      applyStimulus(25'h0017F, 8'h55, 1'b0);
      applyStimulus(25'h00180, 8'h66, 1'b0);
      endDownload(1'b0, "regions");
      checkOutput("regions_byte_count", {14'd0, byte_count}, 32'd6);

      $display("[TB] short image");
      startDownload(8'd0);
      writeImage(int'(TOTAL) - 1, 8'h00);
      endDownload(1'b0, "short");
      repeat (3) @(posedge clk_sys);
      #1;
      checkOutput("short_core_reset_later", {31'd0, core_reset}, 32'd1);

      $display("[TB] out-of-range writes in full image");
      base = dn_wr_seen;
      startDownload(8'd0);
      writeImage(int'(TOTAL), 8'h00);
      applyStimulus({8'd0, TOTAL}, 8'h77, 1'b0);
      applyStimulus(25'h0020005, 8'h88, 1'b0);
      endDownload(1'b0, "overflow");
      checkOutput("overflow_dn_wr_count", 32'(dn_wr_seen - base), {15'd0, TOTAL});
      checkOutput("overflow_byte_count", {14'd0, byte_count}, {15'd0, TOTAL});

      $display("[TB] reset in the middle of a load");
      startDownload(8'd0);
      writeImage(int'(TOTAL) / 2, 8'h00);
      @(posedge clk_sys);
      #1;
      checkOutput("midrst_sb_drained", 32'(sb.size()), 32'd0);
      reset          = 1'b1;
      ioctl_download = 1'b0;
      #1;
      checkOutput("midrst_byte_count", {14'd0, byte_count}, 32'd0);
      checkOutput("midrst_core_reset", {31'd0, core_reset}, 32'd1);
      checkOutput("midrst_dn_addr", {15'd0, dn_addr}, 32'd0);
      checkOutput("midrst_rom_error", {31'd0, rom_error}, 32'd0);
      checkOutput("midrst_rom_ready", {31'd0, rom_ready}, 32'd0);
      repeat (3) @(posedge clk_sys);
      #1;
      reset = 1'b0;
      repeat (5) @(posedge clk_sys);
      #1;
      checkOutput("postrst_core_reset", {31'd0, core_reset}, 32'd1);
      checkOutput("postrst_rom_ready", {31'd0, rom_ready}, 32'd0);
      checkOutput("postrst_dn_wr", {31'd0, dn_wr}, 32'd0);
      startDownload(8'd0);
      writeImage(int'(TOTAL), 8'h00);
      endDownload(1'b1, "reload");

`ifdef ROM_CHECKSUM_EN
      $display("[TB] full image with bad checksum");
      startDownload(8'd0);
      writeImage(int'(TOTAL), 8'h01);
      endDownload(1'b0, "badsum");
      checkOutput("badsum_checksum", {24'd0, checksum}, 32'd1);
`endif

      repeat (3) @(posedge clk_sys);
      #1;
      checkOutput("final_sb_empty", 32'(sb.size()), 32'd0);
      checkOutput("final_dn_wr_total", 32'(dn_wr_seen), 32'(pushes));

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
